// File: rtl/ll_pkg.sv
// Shared definitions for the line-length feature path and seizure detector:
// default feature width and the detector state encoding.
package ll_pkg;

    localparam int FEAT_WIDTH_DEF = 25;

    typedef enum logic [1:0] {
        ST_WARMUP    = 2'd0,
        ST_IDLE      = 2'd1,
        ST_CANDIDATE = 2'd2,
        ST_SEIZURE   = 2'd3
    } det_state_t;

endpackage

// File: rtl/ema_baseline.sv
// Exponential moving average baseline; load seeds it, update applies one EMA step.
// One-cycle latency: the new baseline is visible after the clock edge; no backpressure.
module ema_baseline
    import ll_pkg::*;
#(
    parameter int WIDTH       = FEAT_WIDTH_DEF,
    parameter int ALPHA_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             update,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] baseline
);

    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] step;
    logic [WIDTH-1:0]      ema_next;

    // Difference carries a sign bit so the arithmetic shift floors toward -inf.
    assign diff     = $signed({1'b0, sample}) - $signed({1'b0, baseline});
    assign step     = diff >>> ALPHA_SHIFT;
    assign ema_next = baseline + step[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            baseline <= '0;
        end else if (load) begin
            baseline <= sample;
        end else if (update) begin
            baseline <= ema_next;
        end
    end

endmodule

// File: rtl/seizure_detect.sv
// Threshold-and-persistence seizure detector on a line-length feature stream.
// All outputs registered (one cycle after the deciding sample); en low freezes every register.
module seizure_detect
    import ll_pkg::*;
#(
    parameter int FEAT_WIDTH  = FEAT_WIDTH_DEF,
    parameter int WARMUP_LEN  = 16,
    parameter int ALPHA_SHIFT = 4,
    parameter int THR_SHIFT   = 1,
    parameter int ONSET_CNT   = 4,
    parameter int OFFSET_CNT  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [FEAT_WIDTH-1:0] feat_in,
    input  logic                         feat_valid,
    output logic                         seizure,
    output logic                         onset_pulse,
    output logic                         offset_pulse,
    output logic [FEAT_WIDTH-1:0]        baseline,
    output logic [1:0]                   state
);

    localparam int TW     = FEAT_WIDTH + THR_SHIFT;
    localparam int CNTMAX = (ONSET_CNT > OFFSET_CNT) ? ONSET_CNT : OFFSET_CNT;
    localparam int CW     = $clog2(CNTMAX + 1);
    localparam int WW     = $clog2(WARMUP_LEN + 1);

    det_state_t          st, st_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [WW-1:0]       wcnt, wcnt_n;
    logic                onset_n, offset_n;
    logic                ema_load, ema_update;
    logic                take;
    logic [FEAT_WIDTH-1:0] feat;
    logic [TW-1:0]       thr;
    logic                above;

    assign take  = en & feat_valid;
    assign feat  = feat_in[FEAT_WIDTH-1] ? '0 : feat_in;
    assign thr   = TW'(baseline) << THR_SHIFT;
    assign above = TW'(feat) > thr;
    assign state = st;

    ema_baseline #(
        .WIDTH       (FEAT_WIDTH),
        .ALPHA_SHIFT (ALPHA_SHIFT)
    ) u_ema (
        .clk      (clk),
        .rst      (rst),
        .load     (ema_load),
        .update   (ema_update),
        .sample   (feat),
        .baseline (baseline)
    );

    always_comb begin
        st_n       = st;
        cnt_n      = cnt;
        wcnt_n     = wcnt;
        onset_n    = 1'b0;
        offset_n   = 1'b0;
        ema_load   = 1'b0;
        ema_update = 1'b0;
        if (take) begin
            case (st)
                ST_WARMUP: begin
                    ema_load   = (wcnt == '0);
                    ema_update = (wcnt != '0);
                    wcnt_n     = wcnt + WW'(1);
                    if (wcnt == WW'(WARMUP_LEN - 1)) st_n = ST_IDLE;
                end
                ST_IDLE: begin
                    ema_update = 1'b1;
                    if (above) begin
                        st_n  = ST_CANDIDATE;
                        cnt_n = CW'(1);
                    end
                end
                ST_CANDIDATE: begin
                    if (!above) begin
                        st_n  = ST_IDLE;
                        cnt_n = '0;
                    end else if (cnt == CW'(ONSET_CNT - 1)) begin
                        st_n    = ST_SEIZURE;
                        cnt_n   = '0;
                        onset_n = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_SEIZURE: begin
                    // Any above sample restarts the quiet-run count.
                    if (above) begin
                        cnt_n = '0;
                    end else if (cnt == CW'(OFFSET_CNT - 1)) begin
                        st_n     = ST_IDLE;
                        cnt_n    = '0;
                        offset_n = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: st_n = ST_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= ST_WARMUP;
            cnt          <= '0;
            wcnt         <= '0;
            seizure      <= 1'b0;
            onset_pulse  <= 1'b0;
            offset_pulse <= 1'b0;
        end else begin
            st           <= st_n;
            cnt          <= cnt_n;
            wcnt         <= wcnt_n;
            seizure      <= (st_n == ST_SEIZURE);
            onset_pulse  <= onset_n;
            offset_pulse <= offset_n;
        end
    end

endmodule
